// File: rtl/sc_game_pkg.sv
// sc_game_pkg: definitions shared by the level sequencer and its pause timer.
//   - level_state_t : sequencer state encoding
//   - DEFAULT_*     : default parameter values for sc_levelsequencer
//   - max_int       : elaboration-time helper for sizing the progress compare
// No ports (package).
package sc_game_pkg;

  localparam int DEFAULT_DATAWIDTH   = 5;
  localparam int DEFAULT_TARGET      = 4;
  localparam int DEFAULT_NUMLEVELS   = 4;
  localparam int DEFAULT_PAUSECYCLES = 50000;
  localparam int DEFAULT_LIVES       = 3;

  localparam int PAUSE_W = 16;
  localparam int LEVEL_W = 3;
  localparam int LIVES_W = 3;

  // ST_HIT is the one-cycle progress clear after losing a life; it is only
  // reachable when the lives feature is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_PAUSE = 3'd3,
    ST_WIN   = 3'd4,
    ST_OVER  = 3'd5,
    ST_HIT   = 3'd6
  } level_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sc_levelsequencer_timer.sv
// sc_levelsequencer_timer: 16-bit down-counter used for the inter-level pause.
// Ports:
//   clock, reset   : clock and asynchronous active-high reset (count -> 0)
//   load           : load load_value on the next edge (has priority)
//   decrement      : count down by one on the next edge, saturating at zero
//   load_value     : value to load
//   zero           : high while the count reads zero
module sc_levelsequencer_timer
  import sc_game_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               decrement,
  input  logic [PAUSE_W-1:0] load_value,
  output logic               zero
);

  logic [PAUSE_W-1:0] count;

  // Load wins over decrement so a re-entry always restarts the full dwell.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (decrement && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sc_levelsequencer.sv
// sc_levelsequencer: game level sequencer (IDLE/PLAY/CLEAR/PAUSE/WIN/OVER).
// Moore machine: every output is decoded from registered state and counters.
// Ports:
//   SC_LEVELPROGRESSCOUNTER_CLOCK_50     : clock
//   SC_LEVELPROGRESSCOUNTER_RESET_InHigh : asynchronous active-high reset
//   SC_LEVELSEQUENCER_Progress_InBus     : progress count from the level counter
//   SC_LEVELSEQUENCER_Start_InLow        : start button, active-low level
//   SC_LEVELSEQUENCER_Collision_InLow    : frog-hit strobe, active-low
//   SC_LEVELSEQUENCER_GameActive_Out     : high enables the progress counter
//   SC_LEVELSEQUENCER_LevelClear_OutLow  : low clears the progress counter
//   SC_LEVELSEQUENCER_Level_OutBus       : current level, 0-based
//   SC_LEVELSEQUENCER_Win_Out            : game won
//   SC_LEVELSEQUENCER_GameOver_Out       : game lost (lives feature only)
//   SC_LEVELSEQUENCER_Lives_OutBus       : remaining lives (lives feature only)
// Build option: define SC_LEVELSEQUENCER_LIVES_EN to enable collisions/lives.
// Without it collisions are ignored, GameOver is 0 and Lives reads 0.
module sc_levelsequencer
  import sc_game_pkg::*;
#(
  parameter int LEVELSEQUENCER_DATAWIDTH   = DEFAULT_DATAWIDTH,
  parameter int LEVELSEQUENCER_TARGET      = DEFAULT_TARGET,
  parameter int LEVELSEQUENCER_NUMLEVELS   = DEFAULT_NUMLEVELS,
  parameter int LEVELSEQUENCER_PAUSECYCLES = DEFAULT_PAUSECYCLES,
  parameter int LEVELSEQUENCER_LIVES       = DEFAULT_LIVES
) (
  input  logic                                SC_LEVELPROGRESSCOUNTER_CLOCK_50,
  input  logic                                SC_LEVELPROGRESSCOUNTER_RESET_InHigh,
  input  logic [LEVELSEQUENCER_DATAWIDTH-1:0] SC_LEVELSEQUENCER_Progress_InBus,
  input  logic                                SC_LEVELSEQUENCER_Start_InLow,
  input  logic                                SC_LEVELSEQUENCER_Collision_InLow,
  output logic                                SC_LEVELSEQUENCER_GameActive_Out,
  output logic                                SC_LEVELSEQUENCER_LevelClear_OutLow,
  output logic [2:0]                          SC_LEVELSEQUENCER_Level_OutBus,
  output logic                                SC_LEVELSEQUENCER_Win_Out,
  output logic                                SC_LEVELSEQUENCER_GameOver_Out,
  output logic [2:0]                          SC_LEVELSEQUENCER_Lives_OutBus
);

  // The compare is at least 5 bits wide so the default target always fits.
  localparam int CMP_W = max_int(LEVELSEQUENCER_DATAWIDTH, 5);

  localparam logic [CMP_W-1:0]   TARGET_CMP = CMP_W'(LEVELSEQUENCER_TARGET);
  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(LEVELSEQUENCER_NUMLEVELS - 1);
  localparam logic [PAUSE_W-1:0] PAUSE_LOAD = PAUSE_W'(LEVELSEQUENCER_PAUSECYCLES - 1);

  logic clock;
  logic reset;
  logic start_n;
  logic [CMP_W-1:0] progress_ext;
  logic reached;

  level_state_t state, next_state;
  logic [LEVEL_W-1:0] level, level_next;
  logic timer_load, timer_dec, timer_zero;

  assign clock        = SC_LEVELPROGRESSCOUNTER_CLOCK_50;
  assign reset        = SC_LEVELPROGRESSCOUNTER_RESET_InHigh;
  assign start_n      = SC_LEVELSEQUENCER_Start_InLow;
  assign progress_ext = CMP_W'(SC_LEVELSEQUENCER_Progress_InBus);
  assign reached      = (progress_ext >= TARGET_CMP);

`ifdef SC_LEVELSEQUENCER_LIVES_EN
  logic collision_n;
  logic [LIVES_W-1:0] lives, lives_next;
  assign collision_n = SC_LEVELSEQUENCER_Collision_InLow;
`else
  logic unused_collision;
  assign unused_collision = SC_LEVELSEQUENCER_Collision_InLow;
`endif

  // State, level and lives registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      level <= '0;
`ifdef SC_LEVELSEQUENCER_LIVES_EN
      lives <= LIVES_W'(LEVELSEQUENCER_LIVES);
`endif
    end else begin
      state <= next_state;
      level <= level_next;
`ifdef SC_LEVELSEQUENCER_LIVES_EN
      lives <= lives_next;
`endif
    end
  end

  // Next-state logic. Level completion is tested before collision so a
  // simultaneous hit never costs a life.
  always_comb begin
    next_state = state;
    level_next = level;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
`ifdef SC_LEVELSEQUENCER_LIVES_EN
    lives_next = lives;
`endif
    case (state)
      ST_IDLE: begin
        if (!start_n) begin
          next_state = ST_PLAY;
          level_next = '0;
`ifdef SC_LEVELSEQUENCER_LIVES_EN
          lives_next = LIVES_W'(LEVELSEQUENCER_LIVES);
`endif
        end
      end
      ST_PLAY: begin
        if (reached) begin
          next_state = ST_CLEAR;
`ifdef SC_LEVELSEQUENCER_LIVES_EN
        end else if (!collision_n) begin
          lives_next = lives - 1'b1;
          next_state = (lives == LIVES_W'(1)) ? ST_OVER : ST_HIT;
`endif
        end
      end
      ST_CLEAR: begin
        if (level < LAST_LEVEL) begin
          next_state = ST_PAUSE;
          level_next = level + 1'b1;
          timer_load = 1'b1;
        end else begin
          next_state = ST_WIN;
        end
      end
      ST_PAUSE: begin
        if (timer_zero) begin
          next_state = ST_PLAY;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_HIT: begin
        next_state = ST_PLAY;
      end
      ST_WIN, ST_OVER: begin
        if (!start_n) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  sc_levelsequencer_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .decrement  (timer_dec),
    .load_value (PAUSE_LOAD),
    .zero       (timer_zero)
  );

  // The counter stays enabled through the clear cycle so it sees the clear.
  assign SC_LEVELSEQUENCER_GameActive_Out    = (state == ST_PLAY) || (state == ST_CLEAR) ||
                                               (state == ST_HIT);
  assign SC_LEVELSEQUENCER_LevelClear_OutLow = !((state == ST_CLEAR) || (state == ST_HIT));
  assign SC_LEVELSEQUENCER_Level_OutBus      = level;
  assign SC_LEVELSEQUENCER_Win_Out           = (state == ST_WIN);

`ifdef SC_LEVELSEQUENCER_LIVES_EN
  assign SC_LEVELSEQUENCER_GameOver_Out = (state == ST_OVER);
  assign SC_LEVELSEQUENCER_Lives_OutBus = lives;
`else
  assign SC_LEVELSEQUENCER_GameOver_Out = 1'b0;
  assign SC_LEVELSEQUENCER_Lives_OutBus = 3'd0;
`endif

endmodule

// File: doc/sc_levelsequencer.md
SC_LEVELSEQUENCER -- requirements
Module: sc_levelsequencer

Interface
REQ-001 SHALL have parameter LEVELSEQUENCER_DATAWIDTH, default 5, width of the progress bus.
REQ-002 SHALL have parameter LEVELSEQUENCER_TARGET, default 4, progress count that completes a level.
REQ-003 SHALL have parameter LEVELSEQUENCER_NUMLEVELS, default 4 (range 1..8), levels per game.
REQ-004 SHALL have parameter LEVELSEQUENCER_PAUSECYCLES, default 50000, PAUSE dwell in clocks (1..65535).
REQ-005 SHALL have parameter LEVELSEQUENCER_LIVES, default 3 (range 1..7), lives per game.
REQ-006 SHALL have port SC_LEVELPROGRESSCOUNTER_CLOCK_50  in  1  clock.
REQ-007 SHALL have port SC_LEVELPROGRESSCOUNTER_RESET_InHigh  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port SC_LEVELSEQUENCER_Progress_InBus  in  DATAWIDTH  progress count from the level progress counter.
REQ-009 SHALL have port SC_LEVELSEQUENCER_Start_InLow  in  1  start button, synchronous level, active-low.
REQ-010 SHALL have port SC_LEVELSEQUENCER_Collision_InLow  in  1  frog-hit strobe, active-low.
REQ-011 SHALL have port SC_LEVELSEQUENCER_GameActive_Out  out  1  high = counter enabled (drives counter FinishedGame input).
REQ-012 SHALL have port SC_LEVELSEQUENCER_LevelClear_OutLow  out  1  low = clear progress counter (drives counter LevelFinished input).
REQ-013 SHALL have port SC_LEVELSEQUENCER_Level_OutBus  out  3  current level index, 0-based.
REQ-014 SHALL have ports SC_LEVELSEQUENCER_Win_Out, SC_LEVELSEQUENCER_GameOver_Out (out, 1 each) and SC_LEVELSEQUENCER_Lives_OutBus (out, 3).

Function
REQ-015 SHALL implement states IDLE, PLAY, CLEAR, PAUSE, WIN, OVER; all outputs decoded from registered state/counters only (Moore).
REQ-016 IDLE: GameActive=0, LevelClear=1; Start_InLow=0 -> PLAY next cycle, Level=0, Lives=LIVES.
REQ-017 PLAY: GameActive=1, LevelClear=1; Progress>=TARGET sampled at edge N -> CLEAR from edge N+1.
REQ-018 CLEAR: exactly one cycle, LevelClear=0, GameActive=1; then PAUSE if Level<NUMLEVELS-1 (Level increments on that edge), else WIN (Level held).
REQ-019 PAUSE: GameActive=0; 16-bit down-counter loaded with PAUSECYCLES-1 on entry; PLAY on the edge after it reads 0.
REQ-020 WIN: Win=1, GameActive=0; Start_InLow=0 -> IDLE; OVER identical with GameOver=1.
REQ-021 Start_InLow SHALL be ignored in PLAY, CLEAR and PAUSE.
REQ-022 Progress comparison SHALL be unsigned, zero-extended to max(DATAWIDTH,5); values above TARGET treated as reached.
REQ-023 Collision_InLow SHALL be ignored outside PLAY.

Reset
REQ-024 Reset SHALL force IDLE, Level=0, Lives=LIVES (0 with feature off), pause counter=0, GameActive=0, LevelClear=1, Win=0, GameOver=0, at any point mid-game.

Configuration
REQ-025 Macro SC_LEVELSEQUENCER_LIVES_EN defined: in PLAY, Collision_InLow=0 decrements Lives; if Lives was 1 -> OVER, else -> CLEAR-like one-cycle progress clear, Level unchanged, return to PLAY.
REQ-026 Collision and Progress>=TARGET in the same cycle: level completion wins, Lives unchanged.
REQ-027 Macro undefined: Collision ignored, OVER unreachable, GameOver_Out=0, Lives_OutBus=0 constant; ports retained.

Structure
REQ-028 State encoding typedef and default-parameter constants SHALL live in shared package sc_game_pkg.
REQ-029 Pause timer SHALL be sub-module sc_levelsequencer_timer (load, decrement, zero flag).

Verification
REQ-030 Reset, Start=0 one cycle -> PLAY, GameActive=1, Level=0, Lives=3.
REQ-031 Progress 0..4 in PLAY -> CLEAR at cycle after 4 seen, LevelClear low exactly 1 cycle, Level=1, PAUSE lasts PAUSECYCLES (bench uses 8) then PLAY.
REQ-032 Four completions with NUMLEVELS=4 -> WIN, Win=1, Level=3; Start=0 -> IDLE.
REQ-033 LIVES_EN: three collisions -> Lives 2,1 with clear pulses, third -> OVER, GameOver=1; collision+Progress=4 same cycle -> CLEAR, Lives unchanged.
REQ-034 Reset asserted mid-PAUSE -> IDLE immediately, all outputs at reset values; Start held low during PLAY -> no effect.
